// File: rtl/syscall_responder_if.sv
// Syscall request / console byte-stream bundle between the execute stage,
// the syscall responder, and the console sink.
interface syscall_responder_if;
  logic        syscall_valid;
  logic [31:0] syscall_funct;
  logic [31:0] syscall_param1;
  logic        busy;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        halted;

  modport master (
    output syscall_valid, syscall_funct, syscall_param1, char_ready,
    input  busy, char_data, char_valid, halted
  );

  modport slave (
    input  syscall_valid, syscall_funct, syscall_param1, char_ready,
    output busy, char_data, char_valid, halted
  );
endinterface

// File: rtl/syscall_responder.sv
// Syscall responder: prints signed decimal ints and characters to a byte sink and halts on exit.
// Optional SYSCALL_HEX_EN adds funct 34, printing "0x" plus 8 uppercase hex digits.
module syscall_responder #(
  parameter int INT_DIGITS      = 10,
  parameter int EXIT_CODE_FUNCT = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  syscall_responder_if.slave bus
);

  localparam int          POS_W      = (INT_DIGITS > 1) ? $clog2(INT_DIGITS) : 1;
  localparam logic [31:0] FUNCT_INT  = 32'd1;
  localparam logic [31:0] FUNCT_CHAR = 32'd11;
  localparam logic [31:0] FUNCT_EXIT = 32'(EXIT_CODE_FUNCT);
`ifdef SYSCALL_HEX_EN
  localparam logic [31:0] FUNCT_HEX  = 32'd34;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN,
    S_DIGIT,
    S_EMIT,
`ifdef SYSCALL_HEX_EN
    S_HEX,
`endif
    S_HALT
  } state_t;

  state_t             state, state_d;
  state_t             ret_state, ret_state_d;
  logic [31:0]        mag, mag_d;
  logic [3:0]         digit, digit_d;
  logic [POS_W-1:0]   pos, pos_d;
  logic               started, started_d;
  logic [7:0]         char_q, char_d;
`ifdef SYSCALL_HEX_EN
  logic [3:0]         hex_cnt, hex_cnt_d;
`endif

  function automatic logic [31:0] pow10(input logic [POS_W-1:0] p);
    case (int'(p))
      0:       pow10 = 32'd1;
      1:       pow10 = 32'd10;
      2:       pow10 = 32'd100;
      3:       pow10 = 32'd1000;
      4:       pow10 = 32'd10000;
      5:       pow10 = 32'd100000;
      6:       pow10 = 32'd1000000;
      7:       pow10 = 32'd10000000;
      8:       pow10 = 32'd100000000;
      9:       pow10 = 32'd1000000000;
      default: pow10 = 32'd0;
    endcase
  endfunction

  logic        supported;
  logic [31:0] cur_pow;
  assign cur_pow = pow10(pos);

  always_comb begin
    supported = (bus.syscall_funct == FUNCT_INT) || (bus.syscall_funct == FUNCT_CHAR) ||
                (bus.syscall_funct == FUNCT_EXIT);
`ifdef SYSCALL_HEX_EN
    supported = supported || (bus.syscall_funct == FUNCT_HEX);
`endif
  end

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state;
    ret_state_d = ret_state;
    mag_d       = mag;
    digit_d     = digit;
    pos_d       = pos;
    started_d   = started;
    char_d      = char_q;
`ifdef SYSCALL_HEX_EN
    hex_cnt_d   = hex_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (bus.syscall_valid) begin
          if (bus.syscall_funct == FUNCT_CHAR) begin
            char_d      = bus.syscall_param1[7:0];
            ret_state_d = S_IDLE;
            state_d     = S_EMIT;
          end else if (bus.syscall_funct == FUNCT_INT) begin
            mag_d     = bus.syscall_param1;
            pos_d     = POS_W'(INT_DIGITS - 1);
            digit_d   = 4'd0;
            started_d = 1'b0;
            state_d   = S_SIGN;
          end else if (bus.syscall_funct == FUNCT_EXIT) begin
            state_d = S_HALT;
`ifdef SYSCALL_HEX_EN
          end else if (bus.syscall_funct == FUNCT_HEX) begin
            mag_d     = bus.syscall_param1;
            hex_cnt_d = 4'd0;
            state_d   = S_HEX;
`endif
          end
        end
      end
      S_SIGN: begin
        if (mag[31]) begin
          // Unsigned negation: 0x80000000 stays 2147483648, which is the right magnitude.
          mag_d       = ~mag + 32'd1;
          char_d      = 8'h2D;
          ret_state_d = S_DIGIT;
          state_d     = S_EMIT;
        end else begin
          state_d = S_DIGIT;
        end
      end
      S_DIGIT: begin
        if (mag >= cur_pow) begin
          mag_d   = mag - cur_pow;
          digit_d = digit + 4'd1;
        end else begin
          digit_d = 4'd0;
          if (pos != '0) pos_d = pos - 1'b1;
          if ((digit != 4'd0) || started || (pos == '0)) begin
            char_d      = 8'h30 + {4'd0, digit};
            started_d   = 1'b1;
            ret_state_d = (pos == '0) ? S_IDLE : S_DIGIT;
            state_d     = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (bus.char_ready) state_d = ret_state;
      end
`ifdef SYSCALL_HEX_EN
      S_HEX: begin
        if (hex_cnt == 4'd0) begin
          char_d = 8'h30;
        end else if (hex_cnt == 4'd1) begin
          char_d = 8'h78;
        end else begin
          char_d = (mag[31:28] < 4'd10) ? (8'h30 + {4'd0, mag[31:28]})
                                        : (8'h37 + {4'd0, mag[31:28]});
          mag_d  = mag << 4;
        end
        hex_cnt_d   = hex_cnt + 4'd1;
        ret_state_d = (hex_cnt == 4'd9) ? S_IDLE : S_HEX;
        state_d     = S_EMIT;
      end
`endif
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      mag       <= '0;
      digit     <= '0;
      pos       <= '0;
      started   <= 1'b0;
      char_q    <= '0;
`ifdef SYSCALL_HEX_EN
      hex_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      ret_state <= ret_state_d;
      mag       <= mag_d;
      digit     <= digit_d;
      pos       <= pos_d;
      started   <= started_d;
      char_q    <= char_d;
`ifdef SYSCALL_HEX_EN
      hex_cnt   <= hex_cnt_d;
`endif
    end
  end

  assign bus.busy       = (bus.syscall_valid && supported) || (state != S_IDLE);
  assign bus.char_valid = (state == S_EMIT);
  assign bus.char_data  = char_q;
  assign bus.halted     = (state == S_HALT);

endmodule

// File: tb/tb_syscall_responder.sv
// Directed bench for syscall_responder: decimal/char/exit/reset cases, hex when SYSCALL_HEX_EN is set.
module tb_syscall_responder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] rx[$];

  syscall_responder_if bus ();

  syscall_responder #(.INT_DIGITS(10), .EXIT_CODE_FUNCT(10)) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && bus.char_valid && bus.char_ready) rx.push_back(bus.char_data);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [31:0] funct, input logic [31:0] param,
                       input logic exp_busy);
    step();
    bus.syscall_valid  = 1'b1;
    bus.syscall_funct  = funct;
    bus.syscall_param1 = param;
    #1;
    check({tag, "_busy_accept"}, 32'(bus.busy), 32'(exp_busy));
    step();
    bus.syscall_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 2000; n++) begin
      if (!bus.busy) return;
      step();
    end
    check({tag, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic expect_bytes(input string tag, input string s);
    check({tag, "_len"}, rx.size(), s.len());
    for (int i = 0; i < s.len(); i++)
      if (i < rx.size()) check($sformatf("%s_byte%0d", tag, i), 32'(rx[i]), 32'(s[i]));
  endtask

  task automatic print_test(input string tag, input logic [31:0] funct, input logic [31:0] param,
                            input string s);
    rx.delete();
    issue(tag, funct, param, 1'b1);
    wait_idle(tag);
    expect_bytes(tag, s);
  endtask

  initial begin
    int snap;
    bus.syscall_valid  = 1'b0;
    bus.syscall_funct  = '0;
    bus.syscall_param1 = '0;
    bus.char_ready     = 1'b1;
    #1;
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_valid",  32'(bus.char_valid), 32'd0);
    check("rst_data",   32'(bus.char_data),  32'd0);
    check("rst_halted", 32'(bus.halted),     32'd0);
    #11 rst_n = 1'b1;

    print_test("int305",  32'd1,  32'd305,        "305");
    print_test("int0",    32'd1,  32'd0,          "0");
    print_test("intm7",   32'd1,  32'hFFFF_FFF9,  "-7");
    print_test("intmin",  32'd1,  32'h8000_0000,  "-2147483648");
    print_test("intmax",  32'd1,  32'h7FFF_FFFF,  "2147483647");
    print_test("char",    32'd11, 32'h0000_005A,  "Z");

    // Sink stalls: the byte must sit still with valid high until ready.
    rx.delete();
    bus.char_ready = 1'b0;
    issue("stall", 32'd11, 32'h0000_0141, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.char_valid), 32'd1);
      check("stall_data",  32'(bus.char_data),  32'h41);
      check("stall_busy",  32'(bus.busy),       32'd1);
      step();
    end
    bus.char_ready = 1'b1;
    wait_idle("stall");
    expect_bytes("stall", "A");
    check("stall_valid_drop", 32'(bus.char_valid), 32'd0);

`ifdef SYSCALL_HEX_EN
    print_test("hex", 32'd34, 32'h0000_0A1F, "0x00000A1F");
`else
    rx.delete();
    issue("hexoff", 32'd34, 32'h0000_0A1F, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("hexoff_busy", 32'(bus.busy), 32'd0);
      step();
    end
    check("hexoff_len", rx.size(), 32'd0);
`endif

    print_test("unsup", 32'd1, 32'd42, "42");
    rx.delete();
    issue("ign", 32'd99, 32'd5, 1'b0);
    step();
    check("ign_busy", 32'(bus.busy), 32'd0);
    check("ign_len", rx.size(), 32'd0);

    // Exit: halted and busy stick, further requests are ignored, reset clears.
    rx.delete();
    issue("halt", 32'd10, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("halt_halted", 32'(bus.halted), 32'd1);
      check("halt_busy",   32'(bus.busy),   32'd1);
      step();
    end
    issue("halt_req", 32'd11, 32'h42, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check("halt_len",    rx.size(),           32'd0);
    check("halt_valid",  32'(bus.char_valid), 32'd0);
    check("halt_still",  32'(bus.halted),     32'd1);
    rst_n = 1'b0;
    #1;
    check("halt_rst_halted", 32'(bus.halted),     32'd0);
    check("halt_rst_busy",   32'(bus.busy),       32'd0);
    check("halt_rst_valid",  32'(bus.char_valid), 32'd0);
    step();
    rst_n = 1'b1;

    // Reset in the middle of printing 12345 stops the stream.
    rx.delete();
    issue("abort", 32'd1, 32'd12345, 1'b1);
    for (int n = 0; n < 500 && rx.size() < 2; n++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    snap = rx.size();
    check("abort_snap", snap, 32'd2);
    if (rx.size() >= 2) begin
      check("abort_b0", 32'(rx[0]), 32'h31);
      check("abort_b1", 32'(rx[1]), 32'h32);
    end
    #1;
    check("abort_valid", 32'(bus.char_valid), 32'd0);
    check("abort_busy",  32'(bus.busy),       32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("abort_len", rx.size(), snap);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);

    print_test("recover", 32'd1, 32'hFFFF_FF9C, "-100");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
